// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_OPEN    = 2'd0,
    ARB_LOCK    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Access size encoding in ctrl[1:0]; ctrl[ZEXT_BIT] selects zero-extension.
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam int         ZEXT_BIT  = 2;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// The CPU port is combinational; port 1 is answered one cycle after grant.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ARB_OPEN    | normal arbitration, CPU first unless port 1 has starved
// ARB_LOCK    | port 1 owns memory for a burst, CPU always stalled
// ARB_RELEASE | one cycle where port 1 is held off so the CPU can proceed
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [2:0]            cpu_ctrl,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [2:0]            p1_ctrl,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [2:0]            mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BEAT_END = BW'(BURST_MAX);

  arb_state_t            state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cpu_gnt;
  logic                  p1_g;

  // Grant decode; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    p1_g    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ARB_OPEN: begin
          p1_g    = p1_req & (~cpu_req | (wait_q == WAIT_SAT));
          cpu_gnt = cpu_req & ~p1_g;
        end
        ARB_LOCK:    p1_g    = p1_req;
        ARB_RELEASE: cpu_gnt = cpu_req;
        default: ;
      endcase
    end
  end

  // Next state, starvation and burst counters, port-1 response.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    beat_d   = beat_q;
    rvalid_d = p1_g;
    rdata_d  = p1_g ? mem_rd : rdata_q;
    unique case (state_q)
      ARB_OPEN: begin
        if (p1_g) begin
          wait_d = '0;
        end else if (p1_req && (wait_q != WAIT_SAT)) begin
          wait_d = wait_q + WW'(1);
        end
        if (p1_g && p1_lock) begin
          beat_d  = BW'(1);
          state_d = (BURST_MAX == 1) ? ARB_RELEASE : ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (p1_g) begin
          wait_d = '0;
          beat_d = beat_q + BW'(1);
        end
        if (!p1_lock) begin
          state_d = ARB_OPEN;
        end else if (p1_g && (beat_d == BEAT_END)) begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        wait_d  = '0;
        state_d = ARB_OPEN;
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_OPEN;
      wait_q   <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory mux: the CPU port drives address/control whenever port 1 is not granted.
  assign mem_a     = p1_g ? p1_addr  : cpu_addr;
  assign mem_ctrl  = p1_g ? p1_ctrl  : cpu_ctrl;
  assign mem_wd    = p1_g ? p1_wdata : cpu_wdata;
  assign mem_we    = ((p1_g & p1_we) | (cpu_gnt & cpu_we)) & rst_n;

  assign cpu_rdata = mem_rd;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign p1_gnt    = p1_g;
  assign p1_rvalid = rvalid_q;
  assign p1_rdata  = rdata_q;

endmodule
